// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus width, timeout response word, FSM state encoding, request bundle.
package bus_pkg;

  localparam int BUS_W = 16;

  // Read data returned to a master whose transfer timed out.
  localparam logic [BUS_W-1:0] TMO_DAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_t;

  // One master's request as seen on the shared bus.
  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] dat;
    logic             we;
    logic             cs;
  } bus_req_t;

endpackage

// File: rtl/bus_mux2.sv
// Forwards the selected master onto the slave bus and steers the response back.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the slave's ack (or a forced timeout ack) ends a transfer.
// Ports: en (global enable, low in reset), sel (0=m0, 1=m1), m0_req/m1_req,
//        tmo (force timeout response), s_dat/s_ack (slave), bus_req (to slave),
//        ack_hit (real slave ack accepted), m0_/m1_ dat/ack/err (responses).
module bus_mux2
  import bus_pkg::*;
(
  input  logic             en,
  input  logic             sel,
  input  bus_req_t         m0_req,
  input  bus_req_t         m1_req,
  input  logic             tmo,
  input  logic [BUS_W-1:0] s_dat,
  input  logic             s_ack,
  output bus_req_t         bus_req,
  output logic             ack_hit,
  output logic [BUS_W-1:0] m0_dat,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [BUS_W-1:0] m1_dat,
  output logic             m1_ack,
  output logic             m1_err
);

  bus_req_t         sel_req;
  logic             rsp_ack;
  logic             rsp_err;
  logic [BUS_W-1:0] rsp_dat;

  always_comb begin
    sel_req = sel ? m1_req : m0_req;
    // An unselected or idle master leaves the whole bus at zero.
    bus_req = (en && sel_req.cs) ? sel_req : '0;
    // A slave ack only counts while a transfer is actually presented.
    ack_hit = bus_req.cs & s_ack;
    rsp_ack = ack_hit | (tmo & bus_req.cs);
    // A real ack in the timeout cycle wins, so err is only the forced case.
    rsp_err = rsp_ack & ~ack_hit;
    rsp_dat = ack_hit ? s_dat : (rsp_ack ? TMO_DAT : '0);

    m0_ack  = rsp_ack & ~sel;
    m0_err  = rsp_err & ~sel;
    m0_dat  = sel ? '0 : rsp_dat;
    m1_ack  = rsp_ack & sel;
    m1_err  = rsp_err & sel;
    m1_dat  = sel ? rsp_dat : '0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with m1 lock and per-transfer timeout.
// Latency: grant and forwarding in the request cycle; zero-wait if the slave acks then.
// Backpressure: owner held until slave ack, owner cs drop, or 2^TMO_W-1 BUSY cycles.
// Ports: i_clk, i_reset_n (sync, active low); master 0 i_m0_*/o_m0_*; master 1
//        i_m1_*/o_m1_* plus i_m1_lock; slave o_addr/o_dat/o_we/o_cs, i_dat/i_ack;
//        status o_owner (forwarded master), o_busy (BUSY0/BUSY1).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TMO_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [BUS_W-1:0] i_m0_addr,
  input  logic [BUS_W-1:0] i_m0_dat,
  input  logic             i_m0_we,
  input  logic             i_m0_cs,
  output logic [BUS_W-1:0] o_m0_dat,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  input  logic [BUS_W-1:0] i_m1_addr,
  input  logic [BUS_W-1:0] i_m1_dat,
  input  logic             i_m1_we,
  input  logic             i_m1_cs,
  input  logic             i_m1_lock,
  output logic [BUS_W-1:0] o_m1_dat,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic [BUS_W-1:0] o_addr,
  output logic [BUS_W-1:0] o_dat,
  output logic             o_we,
  output logic             o_cs,
  input  logic [BUS_W-1:0] i_dat,
  input  logic             i_ack,
  output logic             o_owner,
  output logic             o_busy
);

  // Counter value during the last BUSY cycle before the timeout fires;
  // it is cleared on grant, so the (2^TMO_W-1)-th BUSY cycle sees this value.
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'((1 << TMO_W) - 2);

  arb_state_t       state;
  logic             r_last;
  logic [TMO_W-1:0] tmo_cnt;

  bus_req_t m0_req;
  bus_req_t m1_req;
  bus_req_t bus_req;
  logic     sel;
  logic     own_cs;
  logic     busy;
  logic     tmo;
  logic     ack_hit;

  assign m0_req = {i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs};
  assign m1_req = {i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs};

  always_comb begin
    sel = 1'b0;
    case (state)
      // Tie goes to whichever master did not complete the last transfer.
      ST_IDLE:            sel = (i_m0_cs && i_m1_cs) ? ~r_last : i_m1_cs;
      ST_BUSY0:           sel = 1'b0;
      ST_BUSY1, ST_LOCK1: sel = 1'b1;
      default:            sel = 1'b0;
    endcase
  end

  assign own_cs = sel ? i_m1_cs : i_m0_cs;
  assign busy   = (state == ST_BUSY0) || (state == ST_BUSY1);
  assign tmo    = busy && (tmo_cnt == CNT_LAST);

  bus_mux2 u_mux (
    .en      (i_reset_n),
    .sel     (sel),
    .m0_req  (m0_req),
    .m1_req  (m1_req),
    .tmo     (tmo),
    .s_dat   (i_dat),
    .s_ack   (i_ack),
    .bus_req (bus_req),
    .ack_hit (ack_hit),
    .m0_dat  (o_m0_dat),
    .m0_ack  (o_m0_ack),
    .m0_err  (o_m0_err),
    .m1_dat  (o_m1_dat),
    .m1_ack  (o_m1_ack),
    .m1_err  (o_m1_err)
  );

  assign o_addr  = bus_req.addr;
  assign o_dat   = bus_req.dat;
  assign o_we    = bus_req.we;
  assign o_cs    = bus_req.cs;
  assign o_owner = i_reset_n & sel;
  assign o_busy  = i_reset_n & busy;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      r_last  <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      case (state)
        // IDLE and LOCK1 both start a transfer for the selected master;
        // they differ only in how sel was chosen and how an idle cycle exits.
        ST_IDLE, ST_LOCK1: begin
          if (own_cs) begin
            tmo_cnt <= '0;
            if (ack_hit) begin
              r_last <= sel;
              state  <= (sel && i_m1_lock) ? ST_LOCK1 : ST_IDLE;
            end else begin
              state  <= sel ? ST_BUSY1 : ST_BUSY0;
            end
          end else if (state == ST_LOCK1 && !i_m1_lock) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY0, ST_BUSY1: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (!own_cs) begin
            // Abort: the owner gave up, round-robin history is untouched.
            state <= ST_IDLE;
          end else if (ack_hit) begin
            r_last <= sel;
            state  <= (sel && i_m1_lock) ? ST_LOCK1 : ST_IDLE;
          end else if (tmo) begin
            r_last <= sel;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int TMO_W   = 4;
  localparam int TMO_LIM = (1 << TMO_W) - 1;

  localparam logic [15:0] A0 = 16'hA000;
  localparam logic [15:0] D0 = 16'h0D00;
  localparam logic [15:0] A1 = 16'hB111;
  localparam logic [15:0] D1 = 16'h1D11;
  localparam logic [15:0] SD = 16'hC3C3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] m0_addr, m0_dat, m1_addr, m1_dat, s_dat;
  logic        m0_we, m0_cs, m1_we, m1_cs, m1_lock, s_ack;
  logic [15:0] bus_addr, bus_dat, m0_rdat, m1_rdat;
  logic        bus_we, bus_cs, m0_ack, m0_err, m1_ack, m1_err, owner, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TMO_W(TMO_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .i_m0_we(m0_we), .i_m0_cs(m0_cs),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .i_m1_we(m1_we), .i_m1_cs(m1_cs),
    .i_m1_lock(m1_lock),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_addr(bus_addr), .o_dat(bus_dat), .o_we(bus_we), .o_cs(bus_cs),
    .i_dat(s_dat), .i_ack(s_ack),
    .o_owner(owner), .o_busy(busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction view of the arbiter.
  // m_own = master with a transfer outstanding (-1 none), m_lock = m1 holds
  // the bus between transfers, m_last = master that last completed,
  // m_wait = wait cycles already spent by the outstanding transfer.
  int m_own  = -1;
  bit m_lock = 1'b0;
  bit m_last = 1'b1;
  int m_wait = 0;
  int x_fwd;
  bit x_act, x_hit, x_tmo;

  task automatic model_check();
    logic [15:0] e_addr, e_dat, e_rd, e_r0, e_r1;
    logic        e_we, e_cs, e_a0, e_e0, e_a1, e_e1, e_own, e_busy, e_ack, e_err;
    x_fwd = -1; x_act = 0; x_hit = 0; x_tmo = 0;
    e_addr = '0; e_dat = '0; e_rd = '0; e_r0 = '0; e_r1 = '0;
    e_we = 0; e_cs = 0; e_a0 = 0; e_e0 = 0; e_a1 = 0; e_e1 = 0;
    e_own = 0; e_busy = 0; e_ack = 0; e_err = 0;
    if (rst_n) begin
      if (m_own >= 0)            x_fwd = m_own;
      else if (m_lock)           x_fwd = 1;
      else if (m0_cs && m1_cs)   x_fwd = m_last ? 0 : 1;
      else if (m0_cs)            x_fwd = 0;
      else if (m1_cs)            x_fwd = 1;
      x_act = (x_fwd == 0 && m0_cs) || (x_fwd == 1 && m1_cs);
      if (x_act) begin
        e_addr = (x_fwd == 1) ? m1_addr : m0_addr;
        e_dat  = (x_fwd == 1) ? m1_dat  : m0_dat;
        e_we   = (x_fwd == 1) ? m1_we   : m0_we;
        e_cs   = 1'b1;
      end
      x_hit = x_act && s_ack;
      x_tmo = x_act && (m_own >= 0) && (m_wait + 1 == TMO_LIM);
      e_ack = x_hit || x_tmo;
      e_err = x_tmo && !x_hit;
      e_rd  = x_hit ? s_dat : (x_tmo ? 16'hFFFF : 16'h0000);
      if (x_fwd == 0) begin e_a0 = e_ack; e_e0 = e_err; e_r0 = e_rd; end
      if (x_fwd == 1) begin e_a1 = e_ack; e_e1 = e_err; e_r1 = e_rd; end
      e_own  = (x_fwd == 1);
      e_busy = (m_own >= 0);
    end
    chk_vec("model",
      {bus_addr, bus_dat, bus_we, bus_cs, m0_rdat, m0_ack, m0_err,
       m1_rdat, m1_ack, m1_err, owner, busy},
      {e_addr, e_dat, e_we, e_cs, e_r0, e_a0, e_e0, e_r1, e_a1, e_e1, e_own, e_busy});
  endtask

  task automatic model_next();
    if (!rst_n) begin
      m_own = -1; m_lock = 0; m_last = 1; m_wait = 0;
    end else if (m_own >= 0) begin
      if (!x_act) m_own = -1;
      else if (x_hit || x_tmo) begin
        m_last = (m_own == 1);
        m_lock = (m_own == 1) && m1_lock && x_hit;
        m_own  = -1;
      end else m_wait++;
    end else if (x_act) begin
      if (x_hit) begin
        m_last = (x_fwd == 1);
        m_lock = (x_fwd == 1) && m1_lock;
      end else begin
        m_own = x_fwd; m_wait = 0; m_lock = 0;
      end
    end else if (m_lock && !m1_lock) m_lock = 0;
  endtask

  // Inputs are set right after a falling edge; eval samples 2 time units
  // later (well away from the rising edge), tick advances one clock.
  task automatic eval();
    #2;
    model_check();
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst_n = 1; m0_addr = '0; m0_dat = '0; m0_we = 0; m0_cs = 0;
    m1_addr = '0; m1_dat = '0; m1_we = 0; m1_cs = 0; m1_lock = 0;
    s_dat = '0; s_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    eval();
    tick();
    rst_n = 1;
  endtask

  typedef struct packed {
    logic        rst_n, cs0, cs1, ack;
    logic        owner, cs;
    logic [15:0] addr, dat;
    logic        a0, a1;
    logic [15:0] r0, r1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int   got;
    logic exp_o;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, A0,    D0,    1'b0, 1'b0, 16'h0, 16'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, A1,    D1,    1'b0, 1'b0, 16'h0, 16'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, A0,    D0,    1'b0, 1'b0, 16'h0, 16'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A0,    D0,    1'b1, 1'b0, SD,    16'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, A1,    D1,    1'b0, 1'b1, 16'h0, SD};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, A0,    D0,    1'b1, 1'b0, SD,    16'h0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};

    idle_inputs();
    rst_n = 0;
    @(negedge clk);

    // Single-cycle arbitration vectors, each from a fresh reset.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      m0_addr = A0; m0_dat = D0; m0_we = 1'b1;
      m1_addr = A1; m1_dat = D1; m1_we = 1'b0;
      s_dat = SD;
      rst_n = tbl[i].rst_n; m0_cs = tbl[i].cs0; m1_cs = tbl[i].cs1; s_ack = tbl[i].ack;
      eval();
      chk1 ($sformatf("vec%0d_owner", i), owner,    tbl[i].owner);
      chk1 ($sformatf("vec%0d_cs", i),    bus_cs,   tbl[i].cs);
      chk1 ($sformatf("vec%0d_we", i),    bus_we,   tbl[i].cs && !tbl[i].owner);
      chk16($sformatf("vec%0d_addr", i),  bus_addr, tbl[i].addr);
      chk16($sformatf("vec%0d_dat", i),   bus_dat,  tbl[i].dat);
      chk1 ($sformatf("vec%0d_ack0", i),  m0_ack,   tbl[i].a0);
      chk1 ($sformatf("vec%0d_ack1", i),  m1_ack,   tbl[i].a1);
      chk16($sformatf("vec%0d_rd0", i),   m0_rdat,  tbl[i].r0);
      chk16($sformatf("vec%0d_rd1", i),   m1_rdat,  tbl[i].r1);
      chk1 ($sformatf("vec%0d_busy", i),  busy,     1'b0);
      tick();
    end

    // Zero-wait read by m0, then the next tie must go to m1.
    do_reset();
    m0_cs = 1; m0_addr = 16'h0010; s_ack = 1; s_dat = 16'h1234;
    eval();
    chk1 ("zw_ack", m0_ack, 1'b1);
    chk16("zw_dat", m0_rdat, 16'h1234);
    chk1 ("zw_err", m0_err, 1'b0);
    chk1 ("zw_m1ack", m1_ack, 1'b0);
    tick();
    idle_inputs();
    eval();
    chk1("zw_idle", busy, 1'b0);
    tick();
    m0_cs = 1; m1_cs = 1;
    eval();
    chk1("zw_tie_m1", owner, 1'b1);
    tick();

    // Both masters request continuously; slave acks on the third cycle.
    do_reset();
    m0_cs = 1; m1_cs = 1;
    got = 0;
    for (int k = 0; k < 18; k++) begin
      s_ack = (k % 3 == 2);
      s_dat = 16'(k);
      eval();
      if (s_ack) begin
        exp_o = 1'(got % 2);
        chk1($sformatf("rr_owner%0d", got), owner, exp_o);
        chk1($sformatf("rr_ack%0d", got), exp_o ? m1_ack : m0_ack, 1'b1);
        chk1($sformatf("rr_overlap%0d", got), m0_ack & m1_ack, 1'b0);
        got++;
      end
      tick();
    end

    // m1 locks the bus for three writes while m0 waits.
    do_reset();
    m1_cs = 1; m1_lock = 1; m1_we = 1; m0_addr = 16'h0200;
    m1_addr = 16'h0100; s_ack = 1;
    eval();
    chk1("lk_w1_owner", owner, 1'b1);
    chk1("lk_w1_ack", m1_ack, 1'b1);
    tick();
    m0_cs = 1; m1_addr = 16'h0101; s_ack = 0;
    eval();
    chk1("lk_w2a_owner", owner, 1'b1);
    tick();
    s_ack = 1;
    eval();
    chk1("lk_w2b_owner", owner, 1'b1);
    chk1("lk_w2b_ack", m1_ack, 1'b1);
    chk1("lk_w2b_m0ack", m0_ack, 1'b0);
    tick();
    m1_addr = 16'h0102;
    eval();
    chk1 ("lk_w3_owner", owner, 1'b1);
    chk16("lk_w3_addr", bus_addr, 16'h0102);
    tick();
    m1_cs = 0; m1_lock = 0; s_ack = 0;
    eval();
    chk1("lk_rel_owner", owner, 1'b1);
    chk1("lk_rel_cs", bus_cs, 1'b0);
    tick();
    eval();
    chk1 ("lk_m0_owner", owner, 1'b0);
    chk1 ("lk_m0_cs", bus_cs, 1'b1);
    chk16("lk_m0_addr", bus_addr, 16'h0200);
    tick();

    // Slave never answers: forced error response on the last BUSY cycle.
    do_reset();
    m0_cs = 1; m0_addr = 16'h0040;
    eval();
    chk1("to_grant", bus_cs, 1'b1);
    tick();
    for (int k = 1; k <= TMO_LIM; k++) begin
      eval();
      chk1($sformatf("to_ack%0d", k), m0_ack, k == TMO_LIM);
      chk1($sformatf("to_err%0d", k), m0_err, k == TMO_LIM);
      if (k == TMO_LIM) chk16("to_dat", m0_rdat, 16'hFFFF);
      tick();
    end
    m0_cs = 0;
    eval();
    chk1("to_idle", busy, 1'b0);
    tick();

    // A real ack in the timeout cycle wins over the forced error.
    do_reset();
    m0_cs = 1;
    eval();
    tick();
    for (int k = 1; k <= TMO_LIM; k++) begin
      s_ack = (k == TMO_LIM);
      s_dat = 16'h5555;
      eval();
      if (k == TMO_LIM) begin
        chk1 ("tw_ack", m0_ack, 1'b1);
        chk1 ("tw_err", m0_err, 1'b0);
        chk16("tw_dat", m0_rdat, 16'h5555);
      end
      tick();
    end

    // Reset in BUSY0 abandons the transfer.
    do_reset();
    m0_cs = 1;
    eval();
    tick();
    eval();
    chk1("rb_busy", busy, 1'b1);
    tick();
    rst_n = 0; s_ack = 1;
    eval();
    chk1("rb_rst_ack", m0_ack, 1'b0);
    chk1("rb_rst_cs", bus_cs, 1'b0);
    chk1("rb_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1; m0_cs = 0;
    eval();
    chk1("rb_after_busy", busy, 1'b0);
    chk1("rb_after_cs", bus_cs, 1'b0);
    chk1("rb_after_ack", m0_ack, 1'b0);
    tick();

    // m0 aborts in BUSY0; m1 is then granted in the cycle it requests.
    do_reset();
    m0_cs = 1;
    eval();
    tick();
    eval();
    chk1("ab_busy", busy, 1'b1);
    tick();
    m0_cs = 0;
    eval();
    chk1("ab_cs", bus_cs, 1'b0);
    chk1("ab_ack", m0_ack, 1'b0);
    tick();
    m1_cs = 1; m1_addr = 16'h0300;
    eval();
    chk1 ("ab_m1_owner", owner, 1'b1);
    chk1 ("ab_m1_cs", bus_cs, 1'b1);
    chk16("ab_m1_addr", bus_addr, 16'h0300);
    chk1 ("ab_m1_busy", busy, 1'b0);
    tick();

    // Randomized traffic against the reference model; every fourth block of
    // 100 cycles holds requests and withholds acks to reach timeouts.
    do_reset();
    for (int c = 0; c < 2400; c++) begin
      bit quiet;
      quiet = ((c / 100) % 4 == 3);
      rst_n = ($urandom_range(0, 199) != 0);
      m0_cs = m0_cs ? ($urandom_range(0, 99) < (quiet ? 98 : 85)) : ($urandom_range(0, 99) < 40);
      m1_cs = m1_cs ? ($urandom_range(0, 99) < (quiet ? 98 : 85)) : ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 8) m1_lock = ~m1_lock;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = 16'($urandom); m0_dat = 16'($urandom);
      m1_addr = 16'($urandom); m1_dat = 16'($urandom);
      s_ack = !quiet && ($urandom_range(0, 2) == 0);
      s_dat = 16'($urandom);
      eval();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
